// File: rtl/sc_framebuf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sc_framebuf_pkg : shared types and width helpers for the frame buffer    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sc_framebuf_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SCROLL = 1'b1
  } state_t;

  // Width of a field able to hold values 0 .. n-1, never narrower than 1 bit
  function automatic int f_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int C_DEF_ROWS    = 8;
  localparam int C_DEF_COLS    = 8;
  localparam int C_DEF_SCREENS = 8;
  localparam int C_ADDR_W      = f_width(C_DEF_COLS);
  localparam int C_SEL_W       = f_width(C_DEF_SCREENS);
  localparam int C_STEP_W      = f_width(C_DEF_COLS + 1);

endpackage
`default_nettype wire

// File: rtl/sc_framebuf_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sc_framebuf_if : control/display bundle between game logic, frame buffer |
// | and matrix_ctrl. Optional blink input under SC_FRAMEBUF_BLINK_EN.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sc_framebuf_if #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int NUM_SCREENS = 8
);
  import sc_framebuf_pkg::*;

  localparam int SEL_W  = f_width(NUM_SCREENS);
  localparam int ROW_W  = f_width(ROWS);
  localparam int ADDR_W = f_width(COLS);

  logic [NUM_SCREENS*ROWS*COLS-1:0] SC_FRAMEBUF_screenBus_In;
  logic [SEL_W-1:0]                 SC_FRAMEBUF_screenSel_In;
  logic                             SC_FRAMEBUF_load_InLow;
  logic                             SC_FRAMEBUF_scroll_In;
  logic                             SC_FRAMEBUF_clear_InLow;
  logic [ROW_W-1:0]                 SC_FRAMEBUF_shiftRow_In;
  logic                             SC_FRAMEBUF_shiftLeft_In;
  logic                             SC_FRAMEBUF_shiftRight_In;
  logic                             SC_FRAMEBUF_wrap_In;
  logic [ADDR_W-1:0]                SC_FRAMEBUF_dispAddr_In;
  logic [ROWS-1:0]                  SC_FRAMEBUF_dispData_Out;
  logic                             SC_FRAMEBUF_busy_Out;
  logic                             SC_FRAMEBUF_done_Out;
`ifdef SC_FRAMEBUF_BLINK_EN
  logic                             SC_FRAMEBUF_blink_In;
`endif

  modport master (
`ifdef SC_FRAMEBUF_BLINK_EN
    output SC_FRAMEBUF_blink_In,
`endif
    output SC_FRAMEBUF_screenBus_In, SC_FRAMEBUF_screenSel_In, SC_FRAMEBUF_load_InLow,
    output SC_FRAMEBUF_scroll_In, SC_FRAMEBUF_clear_InLow, SC_FRAMEBUF_shiftRow_In,
    output SC_FRAMEBUF_shiftLeft_In, SC_FRAMEBUF_shiftRight_In, SC_FRAMEBUF_wrap_In,
    output SC_FRAMEBUF_dispAddr_In,
    input  SC_FRAMEBUF_dispData_Out, SC_FRAMEBUF_busy_Out, SC_FRAMEBUF_done_Out
  );

  modport slave (
`ifdef SC_FRAMEBUF_BLINK_EN
    input  SC_FRAMEBUF_blink_In,
`endif
    input  SC_FRAMEBUF_screenBus_In, SC_FRAMEBUF_screenSel_In, SC_FRAMEBUF_load_InLow,
    input  SC_FRAMEBUF_scroll_In, SC_FRAMEBUF_clear_InLow, SC_FRAMEBUF_shiftRow_In,
    input  SC_FRAMEBUF_shiftLeft_In, SC_FRAMEBUF_shiftRight_In, SC_FRAMEBUF_wrap_In,
    input  SC_FRAMEBUF_dispAddr_In,
    output SC_FRAMEBUF_dispData_Out, SC_FRAMEBUF_busy_Out, SC_FRAMEBUF_done_Out
  );

endinterface
`default_nettype wire

// File: rtl/sc_framebuf_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sc_framebuf_prescaler : wrap counter producing one tick per PERIOD clocks|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sc_framebuf_prescaler #(
  parameter int WIDTH  = 23,
  parameter int PERIOD = 4000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  logic [WIDTH-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = (r_count == WIDTH'(PERIOD - 1));
  assign o_tick = i_en & ~i_restart & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_restart) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sc_framebuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sc_framebuf : ROWS x COLS LED-matrix frame buffer with load, scroll-in   |
// | and per-row shifting. Optional blink via SC_FRAMEBUF_BLINK_EN.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sc_framebuf
  import sc_framebuf_pkg::*;
#(
  parameter int ROWS                = 8,
  parameter int COLS                = 8,
  parameter int NUM_SCREENS         = 8,
  parameter int PRESCALER_DATAWIDTH = 23,
  parameter int SCROLL_PERIOD       = 4000000
) (
  input  logic         SC_FRAMEBUF_CLOCK_50,
  input  logic         SC_FRAMEBUF_RESET_InLow,
  sc_framebuf_if.slave bus
);

  localparam int ADDR_W = f_width(COLS);
  localparam int SEL_W  = f_width(NUM_SCREENS);
  localparam int ROW_W  = f_width(ROWS);
  localparam int STEP_W = f_width(COLS + 1);

  logic              w_clk;
  logic              w_rst_n;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [COLS-1:0]   r_frame      [ROWS];
  logic [COLS-1:0]   w_frame_nxt  [ROWS];
  logic [COLS-1:0]   r_shadow     [ROWS];
  logic [COLS-1:0]   w_shadow_nxt [ROWS];
  logic [COLS-1:0]   w_sel_row    [ROWS];
  logic [ROWS-1:0]   w_scroll_bit;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_busy;
  logic              w_load;
  logic              w_clear;
  logic              w_scroll_load;
  logic              w_tick;
  logic              w_last_tick;
  logic              w_pre_en;
  logic              w_pre_restart;
  logic              w_shl;
  logic              w_shr;
  logic [ROWS-1:0]   w_disp;

  assign w_clk         = SC_FRAMEBUF_CLOCK_50;
  assign w_rst_n       = SC_FRAMEBUF_RESET_InLow;
  assign w_load        = ~bus.SC_FRAMEBUF_load_InLow;
  assign w_clear       = ~bus.SC_FRAMEBUF_clear_InLow;
  assign w_scroll_load = w_load & bus.SC_FRAMEBUF_scroll_In;
  assign w_shl         = bus.SC_FRAMEBUF_shiftLeft_In & ~bus.SC_FRAMEBUF_shiftRight_In;
  assign w_shr         = bus.SC_FRAMEBUF_shiftRight_In & ~bus.SC_FRAMEBUF_shiftLeft_In;
  assign w_pre_restart = w_clear | w_scroll_load;
  assign w_last_tick   = (r_state == ST_SCROLL) & w_tick & (r_step == STEP_W'(COLS - 1));

`ifdef SC_FRAMEBUF_BLINK_EN
  assign w_pre_en = (r_state == ST_SCROLL) | bus.SC_FRAMEBUF_blink_In;
`else
  assign w_pre_en = (r_state == ST_SCROLL);
`endif

  sc_framebuf_prescaler #(
    .WIDTH  (PRESCALER_DATAWIDTH),
    .PERIOD (SCROLL_PERIOD)
  ) u_prescaler (
    .clk       (w_clk),
    .rst_n     (w_rst_n),
    .i_en      (w_pre_en),
    .i_restart (w_pre_restart),
    .o_tick    (w_tick)
  );

  // Out-of-range selects match no screen and fall through to all zeros
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      w_sel_row[r] = '0;
      for (int s = 0; s < NUM_SCREENS; s++) begin
        if (bus.SC_FRAMEBUF_screenSel_In == SEL_W'(s)) begin
          w_sel_row[r] = bus.SC_FRAMEBUF_screenBus_In[(s*ROWS+r)*COLS +: COLS];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      w_scroll_bit[r] = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        if (r_step == STEP_W'(c)) begin
          w_scroll_bit[r] = r_shadow[r][COLS-1-c];
        end
      end
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = ST_IDLE;
    end else if (w_load) begin
      w_state_nxt = bus.SC_FRAMEBUF_scroll_In ? ST_SCROLL : ST_IDLE;
    end else if (w_last_tick) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    w_busy = (r_state == ST_SCROLL);
  end

  always_comb begin
    w_step_nxt = r_step;
    w_done_nxt = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      w_frame_nxt[r]  = r_frame[r];
      w_shadow_nxt[r] = r_shadow[r];
    end
    if (w_clear) begin
      for (int r = 0; r < ROWS; r++) w_frame_nxt[r] = '0;
    end else if (w_scroll_load) begin
      for (int r = 0; r < ROWS; r++) w_shadow_nxt[r] = w_sel_row[r];
      w_step_nxt = '0;
    end else if (w_load) begin
      for (int r = 0; r < ROWS; r++) w_frame_nxt[r] = w_sel_row[r];
    end else if (r_state == ST_SCROLL) begin
      if (w_tick) begin
        for (int r = 0; r < ROWS; r++) begin
          w_frame_nxt[r] = {r_frame[r][COLS-2:0], w_scroll_bit[r]};
        end
        w_step_nxt = r_step + 1'b1;
      end
      w_done_nxt = w_last_tick;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (bus.SC_FRAMEBUF_shiftRow_In == ROW_W'(r)) begin
          if (w_shl) begin
            w_frame_nxt[r] = {r_frame[r][COLS-2:0],
                              bus.SC_FRAMEBUF_wrap_In & r_frame[r][COLS-1]};
          end else if (w_shr) begin
            w_frame_nxt[r] = {bus.SC_FRAMEBUF_wrap_In & r_frame[r][0],
                              r_frame[r][COLS-1:1]};
          end
        end
      end
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        r_frame[r]  <= '0;
        r_shadow[r] <= '0;
      end
      r_step <= '0;
      r_done <= 1'b0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        r_frame[r]  <= w_frame_nxt[r];
        r_shadow[r] <= w_shadow_nxt[r];
      end
      r_step <= w_step_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Column transpose: row 0 lands in the output MSB, address 0 is the row MSB
  always_comb begin
    w_disp = '0;
    for (int c = 0; c < COLS; c++) begin
      if (bus.SC_FRAMEBUF_dispAddr_In == ADDR_W'(c)) begin
        for (int r = 0; r < ROWS; r++) begin
          w_disp[ROWS-1-r] = r_frame[r][COLS-1-c];
        end
      end
    end
  end

`ifdef SC_FRAMEBUF_BLINK_EN
  logic r_phase;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_phase <= 1'b1;
    end else if (w_tick) begin
      r_phase <= ~r_phase;
    end
  end

  assign bus.SC_FRAMEBUF_dispData_Out = (bus.SC_FRAMEBUF_blink_In & ~r_phase) ? '0 : w_disp;
`else
  assign bus.SC_FRAMEBUF_dispData_Out = w_disp;
`endif

  assign bus.SC_FRAMEBUF_busy_Out = w_busy;
  assign bus.SC_FRAMEBUF_done_Out = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sc_framebuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sc_framebuf : self-checking bench for sc_framebuf (8x8, period 4)     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sc_framebuf;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int NS     = 8;
  localparam int PERIOD = 4;

  logic       clk;
  logic       rst_n;
  int         tests_run;
  int         fails;
  logic [7:0] m_frame [8];
  logic [7:0] obs     [8];
  logic [7:0] screens [8][8];

  sc_framebuf_if #(.ROWS(ROWS), .COLS(COLS), .NUM_SCREENS(NS)) bus ();

  sc_framebuf #(
    .ROWS                (ROWS),
    .COLS                (COLS),
    .NUM_SCREENS         (NS),
    .PRESCALER_DATAWIDTH (23),
    .SCROLL_PERIOD       (PERIOD)
  ) dut (
    .SC_FRAMEBUF_CLOCK_50    (clk),
    .SC_FRAMEBUF_RESET_InLow (rst_n),
    .bus                     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.SC_FRAMEBUF_screenSel_In  = '0;
    bus.SC_FRAMEBUF_load_InLow    = 1'b1;
    bus.SC_FRAMEBUF_scroll_In     = 1'b0;
    bus.SC_FRAMEBUF_clear_InLow   = 1'b1;
    bus.SC_FRAMEBUF_shiftRow_In   = '0;
    bus.SC_FRAMEBUF_shiftLeft_In  = 1'b0;
    bus.SC_FRAMEBUF_shiftRight_In = 1'b0;
    bus.SC_FRAMEBUF_wrap_In       = 1'b0;
    bus.SC_FRAMEBUF_dispAddr_In   = '0;
`ifdef SC_FRAMEBUF_BLINK_EN
    bus.SC_FRAMEBUF_blink_In      = 1'b0;
`endif
  endtask

  task automatic set_bus();
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < ROWS; r++)
        bus.SC_FRAMEBUF_screenBus_In[(s*ROWS+r)*COLS +: COLS] = screens[s][r];
  endtask

  task automatic randomize_screen(input int s);
    for (int r = 0; r < ROWS; r++) screens[s][r] = 8'($urandom);
  endtask

  // Rebuild the visible frame row by row by sweeping every display column
  task automatic read_frame();
    logic [7:0] col;
    for (int a = 0; a < COLS; a++) begin
      bus.SC_FRAMEBUF_dispAddr_In = 3'(a);
      #1;
      col = bus.SC_FRAMEBUF_dispData_Out;
      for (int r = 0; r < ROWS; r++) obs[r][7-a] = col[7-r];
    end
  endtask

  task automatic load_screen(input int sel, input logic scroll);
    bus.SC_FRAMEBUF_screenSel_In = 3'(sel);
    bus.SC_FRAMEBUF_scroll_In    = scroll;
    bus.SC_FRAMEBUF_load_InLow   = 1'b0;
    tick();
    bus.SC_FRAMEBUF_load_InLow   = 1'b1;
    bus.SC_FRAMEBUF_scroll_In    = 1'b0;
  endtask

  task automatic do_shift(input int row, input logic l, input logic rt, input logic wrap);
    int v;
    bus.SC_FRAMEBUF_shiftRow_In   = 3'(row);
    bus.SC_FRAMEBUF_shiftLeft_In  = l;
    bus.SC_FRAMEBUF_shiftRight_In = rt;
    bus.SC_FRAMEBUF_wrap_In       = wrap;
    tick();
    bus.SC_FRAMEBUF_shiftLeft_In  = 1'b0;
    bus.SC_FRAMEBUF_shiftRight_In = 1'b0;
    v = int'(m_frame[row]);
    if (l && !rt)      v = wrap ? (((v * 2) + (v / 128)) % 256) : ((v * 2) % 256);
    else if (rt && !l) v = wrap ? ((v / 2) + (v % 2) * 128) : (v / 2);
    m_frame[row] = v[7:0];
  endtask

  // After k scroll steps a row shows the old row pushed left by k with the
  // top k bits of the target filling in from the right
  function automatic logic [7:0] scroll_row(input logic [7:0] o, input logic [7:0] t, input int k);
    int v;
    if (k >= 8) return t;
    v = ((int'(o) << k) | (int'(t) >> (8 - k))) & 255;
    return v[7:0];
  endfunction

  function automatic logic [7:0] exp_col(input int a);
    logic [7:0] v;
    for (int r = 0; r < ROWS; r++) v[7-r] = m_frame[r][7-a];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if (bus.SC_FRAMEBUF_busy_Out !== 1'b0 || bus.SC_FRAMEBUF_done_Out !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags busy=%b done=%b required 0/0", bus.SC_FRAMEBUF_busy_Out, bus.SC_FRAMEBUF_done_Out);
    end
    read_frame();
    for (int r = 0; r < ROWS; r++) begin
      tests_run++;
      if (obs[r] !== 8'h00) begin
        fails++;
        $display("FAIL reset_row%0d got=%h required=00", r, obs[r]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int r = 0; r < ROWS; r++) m_frame[r] = 8'h00;
  endtask

  task automatic test_instant_load();
    for (int r = 0; r < ROWS; r++) screens[2][r] = 8'h00;
    screens[2][0] = 8'b0001_1000;
    set_bus();
    load_screen(2, 1'b0);
    for (int r = 0; r < ROWS; r++) m_frame[r] = screens[2][r];
    for (int a = 0; a < COLS; a++) begin
      bus.SC_FRAMEBUF_dispAddr_In = 3'(a);
      #1;
      tests_run++;
      if (bus.SC_FRAMEBUF_dispData_Out !== ((a == 3 || a == 4) ? 8'h80 : 8'h00)) begin
        fails++;
        $display("FAIL load_directed_addr%0d got=%h", a, bus.SC_FRAMEBUF_dispData_Out);
      end
    end
    tests_run++;
    if (bus.SC_FRAMEBUF_busy_Out !== 1'b0 || bus.SC_FRAMEBUF_done_Out !== 1'b0) begin
      fails++;
      $display("FAIL load_flags busy=%b done=%b required 0/0", bus.SC_FRAMEBUF_busy_Out, bus.SC_FRAMEBUF_done_Out);
    end
    for (int it = 0; it < 5; it++) begin
      int sel;
      sel = int'($urandom_range(0, NS - 1));
      randomize_screen(sel);
      set_bus();
      load_screen(sel, 1'b0);
      for (int r = 0; r < ROWS; r++) m_frame[r] = screens[sel][r];
      read_frame();
      for (int r = 0; r < ROWS; r++) begin
        tests_run++;
        if (obs[r] !== m_frame[r]) begin
          fails++;
          $display("FAIL load_rand sel=%0d row%0d got=%h required=%h", sel, r, obs[r], m_frame[r]);
        end
      end
    end
  endtask

  task automatic test_scroll();
    logic [7:0] old_f [8];
    logic [7:0] tgt   [8];
    for (int it = 0; it < 2; it++) begin
      if (it == 0) begin
        bus.SC_FRAMEBUF_clear_InLow = 1'b0;
        tick();
        bus.SC_FRAMEBUF_clear_InLow = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
          m_frame[r]    = 8'h00;
          screens[4][r] = 8'hFF;
        end
      end else begin
        randomize_screen(4);
      end
      set_bus();
      old_f = m_frame;
      tgt   = screens[4];
      load_screen(4, 1'b1);
      for (int cyc = 0; cyc <= 36; cyc++) begin
        if (cyc > 0) tick();
        tests_run++;
        if (bus.SC_FRAMEBUF_busy_Out !== (cyc < 32) || bus.SC_FRAMEBUF_done_Out !== (cyc == 32)) begin
          fails++;
          $display("FAIL scroll_flags it=%0d cyc=%0d busy=%b done=%b", it, cyc, bus.SC_FRAMEBUF_busy_Out, bus.SC_FRAMEBUF_done_Out);
        end
        if (cyc % 4 == 0) begin
          read_frame();
          for (int r = 0; r < ROWS; r++) begin
            tests_run++;
            if (obs[r] !== scroll_row(old_f[r], tgt[r], cyc / 4)) begin
              fails++;
              $display("FAIL scroll_frame it=%0d step=%0d row%0d got=%h required=%h", it, cyc / 4, r, obs[r], scroll_row(old_f[r], tgt[r], cyc / 4));
            end
          end
        end
      end
      m_frame = tgt;
    end
  endtask

  task automatic test_shift();
    randomize_screen(5);
    screens[5][5] = 8'b1000_0001;
    set_bus();
    load_screen(5, 1'b0);
    for (int r = 0; r < ROWS; r++) m_frame[r] = screens[5][r];
    do_shift(5, 1'b1, 1'b0, 1'b1);
    read_frame();
    tests_run++;
    if (obs[5] !== 8'b0000_0011) begin
      fails++;
      $display("FAIL shift_left_wrap got=%b required=00000011", obs[5]);
    end
    do_shift(5, 1'b0, 1'b1, 1'b0);
    read_frame();
    tests_run++;
    if (obs[5] !== 8'b0000_0001) begin
      fails++;
      $display("FAIL shift_right_fill got=%b required=00000001", obs[5]);
    end
    do_shift(5, 1'b1, 1'b1, 1'b1);
    read_frame();
    tests_run++;
    if (obs[5] !== 8'b0000_0001) begin
      fails++;
      $display("FAIL shift_both got=%b required=00000001", obs[5]);
    end
    for (int it = 0; it < 16; it++) begin
      do_shift(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
      read_frame();
      for (int r = 0; r < ROWS; r++) begin
        tests_run++;
        if (obs[r] !== m_frame[r]) begin
          fails++;
          $display("FAIL shift_rand it=%0d row%0d got=%h required=%h", it, r, obs[r], m_frame[r]);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] old_f [8];
    int         done_seen;
    int         busy_seen;
    randomize_screen(6);
    set_bus();
    old_f = m_frame;
    load_screen(6, 1'b1);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (cyc == 5) begin
        bus.SC_FRAMEBUF_shiftRow_In  = 3'($urandom_range(0, 7));
        bus.SC_FRAMEBUF_shiftLeft_In = 1'b1;
        bus.SC_FRAMEBUF_wrap_In      = 1'($urandom);
      end
      if (cyc == 6) bus.SC_FRAMEBUF_shiftLeft_In = 1'b0;
      if (cyc == 8) begin
        read_frame();
        for (int r = 0; r < ROWS; r++) begin
          tests_run++;
          if (obs[r] !== scroll_row(old_f[r], screens[6][r], 2)) begin
            fails++;
            $display("FAIL prio_shift_ignored row%0d got=%h required=%h", r, obs[r], scroll_row(old_f[r], screens[6][r], 2));
          end
        end
      end
    end
    bus.SC_FRAMEBUF_clear_InLow = 1'b0;
    bus.SC_FRAMEBUF_load_InLow  = 1'b0;
    bus.SC_FRAMEBUF_scroll_In   = 1'b1;
    tick();
    idle_inputs();
    for (int r = 0; r < ROWS; r++) m_frame[r] = 8'h00;
    read_frame();
    for (int r = 0; r < ROWS; r++) begin
      tests_run++;
      if (obs[r] !== 8'h00) begin
        fails++;
        $display("FAIL prio_clear row%0d got=%h required=00", r, obs[r]);
      end
    end
    done_seen = 0;
    busy_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.SC_FRAMEBUF_done_Out === 1'b1) done_seen++;
      if (bus.SC_FRAMEBUF_busy_Out !== 1'b0) busy_seen++;
      tick();
    end
    tests_run++;
    if (done_seen !== 0 || busy_seen !== 0) begin
      fails++;
      $display("FAIL prio_idle done_cycles=%0d busy_cycles=%0d required 0/0", done_seen, busy_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] old_f [8];
    randomize_screen(1);
    randomize_screen(3);
    set_bus();
    old_f = m_frame;
    load_screen(1, 1'b1);
    repeat (10) tick();
    for (int r = 0; r < ROWS; r++) m_frame[r] = scroll_row(old_f[r], screens[1][r], 2);
    old_f = m_frame;
    load_screen(3, 1'b1);
    for (int cyc = 0; cyc <= 36; cyc++) begin
      if (cyc > 0) tick();
      tests_run++;
      if (bus.SC_FRAMEBUF_busy_Out !== (cyc < 32) || bus.SC_FRAMEBUF_done_Out !== (cyc == 32)) begin
        fails++;
        $display("FAIL b2b_flags cyc=%0d busy=%b done=%b", cyc, bus.SC_FRAMEBUF_busy_Out, bus.SC_FRAMEBUF_done_Out);
      end
      if (cyc % 8 == 0) begin
        read_frame();
        for (int r = 0; r < ROWS; r++) begin
          tests_run++;
          if (obs[r] !== scroll_row(old_f[r], screens[3][r], cyc / 4)) begin
            fails++;
            $display("FAIL b2b_frame step=%0d row%0d got=%h required=%h", cyc / 4, r, obs[r], scroll_row(old_f[r], screens[3][r], cyc / 4));
          end
        end
      end
    end
    m_frame = screens[3];
  endtask

  task automatic test_reset_mid_scroll();
    int done_seen;
    randomize_screen(7);
    screens[7][0] = 8'hFF;
    set_bus();
    load_screen(7, 1'b1);
    repeat (13) tick();
    #4;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.SC_FRAMEBUF_busy_Out !== 1'b0 || bus.SC_FRAMEBUF_done_Out !== 1'b0) begin
      fails++;
      $display("FAIL midreset_flags busy=%b done=%b required 0/0", bus.SC_FRAMEBUF_busy_Out, bus.SC_FRAMEBUF_done_Out);
    end
    read_frame();
    for (int r = 0; r < ROWS; r++) begin
      tests_run++;
      if (obs[r] !== 8'h00) begin
        fails++;
        $display("FAIL midreset_row%0d got=%h required=00", r, obs[r]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < ROWS; r++) m_frame[r] = 8'h00;
    done_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (bus.SC_FRAMEBUF_done_Out !== 1'b0 || bus.SC_FRAMEBUF_busy_Out !== 1'b0) done_seen++;
    end
    tests_run++;
    if (done_seen !== 0) begin
      fails++;
      $display("FAIL midreset_after flagged_cycles=%0d required=0", done_seen);
    end
  endtask

`ifdef SC_FRAMEBUF_BLINK_EN
  task automatic test_blink();
    logic [7:0] col;
    rst_n = 1'b0;
    #5;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    randomize_screen(0);
    screens[0][0] = 8'hA5;
    set_bus();
    load_screen(0, 1'b0);
    for (int r = 0; r < ROWS; r++) m_frame[r] = screens[0][r];
    col = exp_col(0);
    bus.SC_FRAMEBUF_dispAddr_In = 3'd0;
    bus.SC_FRAMEBUF_blink_In    = 1'b1;
    #1;
    for (int n = 0; n < 24; n++) begin
      if (n > 0) tick();
      tests_run++;
      if (bus.SC_FRAMEBUF_dispData_Out !== ((((n / 4) % 2) == 0) ? col : 8'h00)) begin
        fails++;
        $display("FAIL blink_on n=%0d got=%h", n, bus.SC_FRAMEBUF_dispData_Out);
      end
    end
    bus.SC_FRAMEBUF_blink_In = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      tests_run++;
      if (bus.SC_FRAMEBUF_dispData_Out !== col) begin
        fails++;
        $display("FAIL blink_off n=%0d got=%h required=%h", n, bus.SC_FRAMEBUF_dispData_Out, col);
      end
    end
  endtask
`endif

  initial begin
    tests_run = 0;
    fails     = 0;
    rst_n     = 1'b0;
    bus.SC_FRAMEBUF_screenBus_In = '0;
    idle_inputs();
    for (int s = 0; s < NS; s++) randomize_screen(s);
    set_bus();
    test_reset();
    test_instant_load();
    test_scroll();
    test_shift();
    test_priority();
    test_back_to_back();
    test_reset_mid_scroll();
`ifdef SC_FRAMEBUF_BLINK_EN
    test_blink();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sc_framebuf.md
Name: sc_framebuf

Overview:
- Parametrised ROWS x COLS frame buffer for the LED-matrix game path.
- Sits between the game control logic (screen select, player shift commands) and matrix_ctrl.
- Replaces fixed-pattern wiring plus the column-transpose mux with a stateful buffer.
- Supports instant screen load, animated scroll-in of a new screen, and per-row player shifting with wrap or zero-fill.

Parameters:
- ROWS, 8, number of matrix rows (register rows)
- COLS, 8, bits per row / number of display columns
- NUM_SCREENS, 8, number of selectable fixed patterns on the screen bus
- PRESCALER_DATAWIDTH, 23, width of scroll tick counter
- SCROLL_PERIOD, 4000000, clock cycles per scroll step; must be >= 2 and < 2**PRESCALER_DATAWIDTH

Ports:
- SC_FRAMEBUF_CLOCK_50  in  1  system clock; the only clock
- SC_FRAMEBUF_RESET_InLow  in  1  asynchronous, active-low reset
- SC_FRAMEBUF_screenBus_In  in  NUM_SCREENS*ROWS*COLS  flattened patterns; screen s, row r at [(s*ROWS+r)*COLS +: COLS]
- SC_FRAMEBUF_screenSel_In  in  clog2(NUM_SCREENS)  pattern index for load
- SC_FRAMEBUF_load_InLow  in  1  0 = load selected screen
- SC_FRAMEBUF_scroll_In  in  1  sampled with load: 1 = scroll-in, 0 = instant
- SC_FRAMEBUF_clear_InLow  in  1  0 = clear frame, abort scroll
- SC_FRAMEBUF_shiftRow_In  in  clog2(ROWS)  row targeted by shift
- SC_FRAMEBUF_shiftLeft_In  in  1  shift target row toward MSB
- SC_FRAMEBUF_shiftRight_In  in  1  shift target row toward LSB
- SC_FRAMEBUF_wrap_In  in  1  1 = rotate, 0 = zero-fill
- SC_FRAMEBUF_dispAddr_In  in  clog2(COLS)  column address from matrix_ctrl
- SC_FRAMEBUF_dispData_Out  out  ROWS  transposed column for matrix_ctrl
- SC_FRAMEBUF_busy_Out  out  1  high while scrolling
- SC_FRAMEBUF_done_Out  out  1  one-cycle pulse at scroll completion

Behaviour:
Reset:
- Async assert: frame = all zeros; state = IDLE; prescaler = 0; busy = 0; done = 0.
- Release is sampled synchronously.

Read path (combinational from frame registers):
- dispData for address a = {frame[0][COLS-1-a], frame[1][COLS-1-a], ..., frame[ROWS-1][COLS-1-a]}.
- a = 0 returns the row MSBs, with row 0 in the output MSB.
- Address >= COLS returns 0.

Per-cycle priority: clear > load > shift.
- Clear (IDLE or SCROLL): frame = 0, state -> IDLE, prescaler = 0, no done pulse.
- Load, scroll = 0: frame = selected screen on the next edge; stays IDLE; done not pulsed.
- Load, scroll = 1:
  - Latch the target pattern into a shadow buffer and set step = 0, prescaler = 0.
  - State -> SCROLL; busy = 1 from the next cycle.
  - Load during SCROLL restarts with the new target.
- screenSel >= NUM_SCREENS loads all zeros.
- Load is level-sensitive: held low, it reloads every cycle and a scroll restarts every cycle.

SCROLL state:
- Prescaler counts 0 .. SCROLL_PERIOD-1; a tick occurs at wrap.
- On each tick, every row r becomes {frame[r][COLS-2:0], shadow[r][COLS-1-step]}; step increments.
- After tick number COLS the frame equals the target; state -> IDLE, busy = 0, done = 1 for exactly one cycle.

Shift (IDLE only; ignored in SCROLL):
- Left: row = {row[COLS-2:0], fill}, where fill = wrap ? row[COLS-1] : 0.
- Right: row = {fill, row[COLS-1:1]}, where fill = wrap ? row[0] : 0.
- Left and right both asserted: no change. shiftRow >= ROWS: ignored.
- One shift per cycle while asserted; callers supply debounced single-cycle pulses.

Optional Feature:
- Macro: SC_FRAMEBUF_BLINK_EN.
- Defined:
  - Adds input SC_FRAMEBUF_blink_In (1 bit).
  - A blink phase flop toggles on every prescaler wrap; the prescaler free-runs in IDLE when blink_In = 1.
  - dispData is forced to 0 while blink_In = 1 and phase = 0.
  - Phase resets to 1.
- Undefined: no port, no phase flop; the prescaler runs only in SCROLL.

Decomposition:
- Package sc_framebuf_pkg holds:
  - state typedef (IDLE, SCROLL)
  - clog2-based width localparams: address, select, and step (clog2(COLS+1))
- One sub-module, sc_framebuf_prescaler: counter plus tick generator, with enable and synchronous restart inputs.

Test Plan:
(Bench overrides SCROLL_PERIOD = 4.)
1. Reset mid-scroll: assert RESET_InLow low during step 3 -> all dispData = 0x00, busy = 0 immediately (async), done never pulses.
2. Instant load: screen 2, row0 = 8'b00011000, others 0, load low 1 cycle -> addr 3 and addr 4 give dispData = 8'b10000000; other addrs give 0; busy stays 0.
3. Scroll-in: target all rows = 8'hFF, frame 0, scroll = 1 -> busy high for 8*4 cycles; after tick k, dispData at addr 8-k = 0xFF; done pulses once; final frame = 0xFF.
4. Shift with wrap: row 5 = 8'b10000001, shiftLeft, wrap = 1 -> 8'b00000011; then shiftRight, wrap = 0 -> 8'b00000001; left+right together -> unchanged.
5. Priority: clear and load asserted together during SCROLL -> frame 0, IDLE, no done; shift pulse during SCROLL -> ignored.
6. Blink (SC_FRAMEBUF_BLINK_EN defined): frame loaded, blink_In = 1 -> dispData alternates frame/0 every 4 cycles; blink_In = 0 -> steady frame.
